// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch front-end bundle: redirect, imem request/response and
//               IF/ID instruction handshake.
// Revision    : 1.0
// ============================================================================
interface fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] fetch_pc;

    modport master (
        input  redirect,
        input  redirect_pc,
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        output fetch_pc
    );

    modport slave (
        output redirect,
        output redirect_pc,
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        output mem_rsp_valid,
        output mem_rsp_data,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        input  fetch_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Sequential instruction fetch with credit-limited imem requests,
//               in-order response buffering and redirect flush.
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  wire logic     clock,
    input  wire logic     reset,
    fetch_queue_if.master bus
);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = ((OW > CW) ? OW : CW) + 1;

    localparam logic [OW-1:0] C_MAX_OUT   = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] C_DEPTH     = SW'(DEPTH);
    localparam logic [PW-1:0] C_LAST_SLOT = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc_q,    fetch_pc_d;
    logic [31:0]   rsp_pc_q,      rsp_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q,    drop_cnt_d;
    logic [CW-1:0] count_q,       count_d;
    logic [PW-1:0] wr_ptr_q,      wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,      rd_ptr_d;
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_pc_d   [DEPTH];

    logic          fifo_nonempty;
    logic [SW-1:0] credits_used;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          pop;
    logic          redirect_pc_unused;

    // Fetch targets are word aligned; the low redirect bits are dropped.
    assign redirect_pc_unused = ^bus.redirect_pc[1:0];

    always_comb begin
        fifo_nonempty = (count_q != '0);
        credits_used  = SW'(outstanding_q) + SW'(count_q);
        // Every issued request reserves a FIFO slot, so a response can never overflow.
        req_valid     = !reset && !bus.redirect
                        && (outstanding_q < C_MAX_OUT)
                        && (credits_used < C_DEPTH);
        req_fire      = req_valid && bus.mem_req_ready;
        rsp_fire      = bus.mem_rsp_valid && (outstanding_q != '0);
        rsp_keep      = rsp_fire && (drop_cnt_q == '0) && !bus.redirect;
        rsp_drop      = rsp_fire && (drop_cnt_q != '0) && !bus.redirect;
        pop           = fifo_nonempty && !bus.redirect && bus.inst_ready;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_data_d   = fifo_data_q;
        fifo_pc_d     = fifo_pc_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_fire);

        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {bus.redirect_pc[31:2], 2'b00};
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_d = outstanding_q - OW'(rsp_fire);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_keep) begin
                fifo_data_d[wr_ptr_q] = bus.mem_rsp_data;
                fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
                wr_ptr_d              = (wr_ptr_q == C_LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
                rsp_pc_d              = rsp_pc_q + 32'd4;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - OW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == C_LAST_SLOT) ? '0 : rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_data_q   <= '{default: '0};
            fifo_pc_q     <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_data_q   <= fifo_data_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.fetch_pc      = fetch_pc_q;
    assign bus.inst_valid    = fifo_nonempty && !bus.redirect;
    assign bus.inst_data     = fifo_nonempty ? fifo_data_q[rd_ptr_q] : 32'd0;
    assign bus.inst_pc       = fifo_nonempty ? fifo_pc_q[rd_ptr_q]   : 32'd0;
endmodule
`default_nettype wire
